// File: rtl/sync_pkg.sv
// Shared constants, counter sizing and parameter checks for multi_ch_sync_filter.
// The optional glitch filter is built only when MULTI_CH_SYNC_FILTER_EN is defined.
`ifndef SYNC_PKG_SV
`define SYNC_PKG_SV

// Elaboration-time lower-bound check; expands to a named generate-if.
`define SYNC_CHECK_MIN(val, minv, blk) \
  if ((val) < (minv)) begin : blk \
    $error("multi_ch_sync_filter: parameter value %0d below minimum %0d", (val), (minv)); \
  end

package sync_pkg;

  localparam int unsigned SYNC_MIN_STAGES = 2;
  localparam int unsigned SYNC_MIN_FILT   = 1;

  // Filter counter width; never narrower than one bit so FILT_LEN=1 still builds.
  function automatic int unsigned sync_cnt_width(input int unsigned len);
    if (len <= 32'd1) return 32'd1;
    return 32'($clog2(len));
  endfunction

endpackage

`endif

// File: rtl/multi_ch_sync_filter_if.sv
// Signal bundle between multi_ch_sync_filter and its user: async inputs in,
// synchronised levels and edge pulses out.
interface multi_ch_sync_filter_if #(
  parameter int unsigned CH = 8
);
  logic [CH-1:0] async_in;
  logic [CH-1:0] sync_out;
  logic [CH-1:0] rise_pulse;
  logic [CH-1:0] fall_pulse;
  logic          any_change;

  modport master (
    output async_in,
    input  sync_out, rise_pulse, fall_pulse, any_change
  );

  modport slave (
    input  async_in,
    output sync_out, rise_pulse, fall_pulse, any_change
  );
endinterface

// File: rtl/sync_chain_ch.sv
// One channel: STAGES-deep synchroniser, optional glitch filter (MULTI_CH_SYNC_FILTER_EN),
// registered level and rise/fall pulses.
module sync_chain_ch
  import sync_pkg::*;
#(
  parameter int unsigned STAGES   = 2,
  parameter int unsigned FILT_LEN = 4,
  parameter bit          RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic change_c
);

  `SYNC_CHECK_MIN(STAGES, SYNC_MIN_STAGES, g_bad_stages)
  `SYNC_CHECK_MIN(FILT_LEN, SYNC_MIN_FILT, g_bad_filt)

  logic [STAGES-1:0] chain;
  logic              sync_nxt;

  // chain[0] is the metastability-exposed capture flop; chain[STAGES-1] is the settled level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= {STAGES{RST_VAL}};
    else     chain <= {chain[STAGES-2:0], async_in};
  end

`ifdef MULTI_CH_SYNC_FILTER_EN
  localparam int unsigned CW = sync_cnt_width(FILT_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Accept a new level only after it has differed from sync_out for FILT_LEN edges.
  always_comb begin
    sync_nxt = sync_out;
    cnt_nxt  = '0;
    if (chain[STAGES-1] != sync_out) begin
      if (cnt == CNT_LAST) sync_nxt = chain[STAGES-1];
      else                 cnt_nxt  = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end
`else
  assign sync_nxt = chain[STAGES-1];
`endif

  assign change_c = sync_nxt ^ sync_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_out   <= RST_VAL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_out   <= sync_nxt;
      rise_pulse <= sync_nxt & ~sync_out;
      fall_pulse <= ~sync_nxt & sync_out;
    end
  end

endmodule

// File: rtl/multi_ch_sync_filter.sv
// CH independent single-bit synchronisers with optional glitch filter
// (MULTI_CH_SYNC_FILTER_EN) and per-channel edge pulses. Not for coherent buses.
module multi_ch_sync_filter
  import sync_pkg::*;
#(
  parameter int unsigned   CH       = 8,
  parameter int unsigned   STAGES   = 2,
  parameter int unsigned   FILT_LEN = 4,
  parameter logic [CH-1:0] RST_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_ch_sync_filter_if.slave bus
);

  `SYNC_CHECK_MIN(CH, SYNC_MIN_FILT, g_bad_ch)

  logic [CH-1:0] sync_w;
  logic [CH-1:0] rise_w;
  logic [CH-1:0] fall_w;
  logic [CH-1:0] change_c;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    sync_chain_ch #(
      .STAGES   (STAGES),
      .FILT_LEN (FILT_LEN),
      .RST_VAL  (RST_VAL[i])
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .async_in   (bus.async_in[i]),
      .sync_out   (sync_w[i]),
      .rise_pulse (rise_w[i]),
      .fall_pulse (fall_w[i]),
      .change_c   (change_c[i])
    );
  end

  assign bus.sync_out   = sync_w;
  assign bus.rise_pulse = rise_w;
  assign bus.fall_pulse = fall_w;

  // Registered on the same edge as the per-channel pulses so it lines up with them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.any_change <= 1'b0;
    else     bus.any_change <= |change_c;
  end

endmodule
